// File: rtl/otbn_rnd_source_if.sv
// ----------------------------------------------------------------------------
// otbn_rnd_source_if
//
// Bundles the signals between the deterministic entropy source and the OTBN
// core's randomness inputs.
//
//   rnd_ack      consumer -> source  current rnd_data has been taken
//   urnd_advance consumer -> source  step the URND LFSR this cycle
//   rnd_valid    source -> consumer  rnd_data holds a complete fresh word
//   rnd_data     source -> consumer  256-bit RND word
//   urnd_data    source -> consumer  current 256-bit URND LFSR state
//   rnd_served   source -> consumer  saturating count of acknowledged words
//
// The master modport is the entropy source; the slave modport is the consumer.
// ----------------------------------------------------------------------------
interface otbn_rnd_source_if;
    logic         rnd_ack;
    logic         urnd_advance;
    logic         rnd_valid;
    logic [255:0] rnd_data;
    logic [255:0] urnd_data;
    logic [15:0]  rnd_served;

    modport master (
        input  rnd_ack,
        input  urnd_advance,
        output rnd_valid,
        output rnd_data,
        output urnd_data,
        output rnd_served
    );

    modport slave (
        output rnd_ack,
        output urnd_advance,
        input  rnd_valid,
        input  rnd_data,
        input  urnd_data,
        input  rnd_served
    );
endinterface

// File: rtl/otbn_rnd_source.sv
// ----------------------------------------------------------------------------
// otbn_rnd_source
//
// Deterministic entropy source feeding the OTBN core's RND and URND inputs.
// RND: a 64-bit xorshift generator produces one chunk per cycle; four chunks
// are assembled into a 256-bit word which is then offered with a valid/ack
// handshake. URND: a free-running 256-bit Fibonacci LFSR stepped on request.
// All output is reproducible from the two seed parameters.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset; overrides every other input
//   bus    otbn_rnd_source_if.master (rnd_ack, urnd_advance in;
//          rnd_valid, rnd_data, urnd_data, rnd_served out)
// ----------------------------------------------------------------------------
module otbn_rnd_source #(
    parameter logic [63:0]  RND_SEED  = 64'h0000000000000001,
    parameter logic [255:0] URND_SEED = 256'h1
) (
    input  logic                clk,
    input  logic                reset,
    otbn_rnd_source_if.master   bus
);

    // A zero seed would lock either generator at zero forever.
    localparam logic [63:0]  RND_INIT  = (RND_SEED  == 64'd0)  ? 64'd1  : RND_SEED;
    localparam logic [255:0] URND_INIT = (URND_SEED == 256'd0) ? 256'd1 : URND_SEED;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t       state_reg, state_next;
    logic [1:0]   idx_reg, idx_next;
    logic [63:0]  x_reg, x_next;
    logic         valid_reg, valid_next;
    logic [15:0]  served_reg, served_next;
    logic [255:0] urnd_reg, urnd_next;

    logic         fill_en;     // write the current chunk this cycle
    logic         clear_word;  // wipe the word after it was taken

    // xorshift64 step; t3 is both the next state and the emitted chunk.
    logic [63:0] t1, t2, t3;
    always_comb begin
        t1 = x_reg ^ (x_reg << 13);
        t2 = t1 ^ (t1 >> 7);
        t3 = t2 ^ (t2 << 17);
    end

    // Next-state and control for the fill/handshake FSM.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        x_next      = x_reg;
        valid_next  = valid_reg;
        served_next = served_reg;
        fill_en     = 1'b0;
        clear_word  = 1'b0;
        case (state_reg)
            FILL: begin
                // rnd_ack is deliberately ignored while filling.
                fill_en  = 1'b1;
                x_next   = t3;
                idx_next = idx_reg + 2'd1;
                if (idx_reg == 2'd3) begin
                    state_next = FULL;
                    valid_next = 1'b1;
                end
            end
            FULL: begin
                if (bus.rnd_ack) begin
                    valid_next = 1'b0;
                    clear_word = 1'b1;
                    if (served_reg != 16'hFFFF) begin
                        served_next = served_reg + 16'd1;
                    end
                    state_next = FILL;
                    idx_next   = 2'd0;
                end
            end
            default: begin
                state_next = FILL;
                idx_next   = 2'd0;
            end
        endcase
    end

    // URND LFSR, taps 256/254/251/246, independent of the RND FSM.
    logic urnd_fb;
    always_comb begin
        urnd_fb   = urnd_reg[255] ^ urnd_reg[253] ^ urnd_reg[250] ^ urnd_reg[245];
        urnd_next = urnd_reg;
        if (bus.urnd_advance) begin
            urnd_next = {urnd_reg[254:0], urnd_fb};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= FILL;
            idx_reg    <= 2'd0;
            x_reg      <= RND_INIT;
            valid_reg  <= 1'b0;
            served_reg <= 16'd0;
            urnd_reg   <= URND_INIT;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            x_reg      <= x_next;
            valid_reg  <= valid_next;
            served_reg <= served_next;
            urnd_reg   <= urnd_next;
        end
    end

    // One 64-bit register per chunk of the RND word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_chunk
        logic [63:0] chunk_reg, chunk_next;

        always_comb begin
            chunk_next = chunk_reg;
            if (clear_word) begin
                chunk_next = 64'd0;
            end else if (fill_en && (idx_reg == 2'(gi))) begin
                chunk_next = t3;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                chunk_reg <= 64'd0;
            end else begin
                chunk_reg <= chunk_next;
            end
        end
    end

    assign bus.rnd_data   = {g_chunk[3].chunk_reg, g_chunk[2].chunk_reg,
                             g_chunk[1].chunk_reg, g_chunk[0].chunk_reg};
    assign bus.rnd_valid  = valid_reg;
    assign bus.rnd_served = served_reg;
    assign bus.urnd_data  = urnd_reg;

endmodule
